id_ex_stage: RTL and testbench

- ID/EX pipeline register. Sits directly downstream of the register unit.
- Captures RU1/RU2 together with the decoded fields and control of the instruction in ID, and presents them to EX one cycle later.
- Detects load-use hazards. On a hazard it holds IF/ID and inserts a bubble. A branch-taken flush from EX kills the instruction in ID.
- Optional bypass of the same-cycle write-back value. Saturating stall and flush counters for debug.

---
 rtl/id_ex_stage.sv | 124 ++++++++++++
 tb/tb_id_ex_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and flush.
// Optional same-cycle WB bypass when ID_EX_WB_BYPASS_EN is defined.
//
// Ports:
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   id_*          : decoded fields/control of the instruction in ID
//   ru1, ru2      : register unit read data for RS1/RS2
//   wb_*          : write-back port (used only by the bypass option)
//   ex_flush      : branch/jump taken in EX, kills the ID instruction
//   stall_if_id   : combinational hold request for PC and IF/ID
//   ex_*          : registered bundle presented to EX
//   stall_cnt     : saturating count of load-use stall cycles
//   flush_cnt     : saturating count of flush cycles
module id_ex_stage #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_ruwr,
    input  logic              id_dmrd,
    input  logic [31:0]       ru1,
    input  logic [31:0]       ru2,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_data,
    input  logic              wb_ruwr,
    input  logic              ex_flush,
    output logic              stall_if_id,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [31:0]       ex_a,
    output logic [31:0]       ex_b,
    output logic [31:0]       ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_ruwr,
    output logic              ex_dmrd,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic        hz;
    logic [31:0] opa;
    logic [31:0] opb;

    // Load in EX whose result the ID instruction needs; x0 never matches.
    assign hz = ex_valid & ex_dmrd & (ex_rd != 5'd0) & id_valid &
                ((id_rs1 == ex_rd) | (id_rs2 == ex_rd));

    // A flush discards the ID instruction, so holding it would be pointless.
    assign stall_if_id = hz & ~ex_flush & ~rst;

`ifdef ID_EX_WB_BYPASS_EN
    // WB writes the register unit in the same cycle ID reads it.
    logic hit1;
    logic hit2;

    assign hit1 = wb_ruwr & (wb_rd != 5'd0) & (wb_rd == id_rs1);
    assign hit2 = wb_ruwr & (wb_rd != 5'd0) & (wb_rd == id_rs2);
    assign opa  = hit1 ? wb_data : ru1;
    assign opb  = hit2 ? wb_data : ru2;
`else
    logic unused_wb;

    assign unused_wb = ^{wb_rd, wb_data, wb_ruwr};
    assign opa       = ru1;
    assign opb       = ru2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_pc     <= '0;
            ex_rs1    <= '0;
            ex_rs2    <= '0;
            ex_rd     <= '0;
            ex_a      <= '0;
            ex_b      <= '0;
            ex_imm    <= '0;
            ex_ctrl   <= '0;
            ex_ruwr   <= 1'b0;
            ex_dmrd   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (ex_flush) begin
            ex_valid <= 1'b0;
            ex_ruwr  <= 1'b0;
            ex_dmrd  <= 1'b0;
            if (~&flush_cnt) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end else if (hz) begin
            // Bubble; data fields hold and upstream keeps the ID instruction.
            ex_valid <= 1'b0;
            ex_ruwr  <= 1'b0;
            ex_dmrd  <= 1'b0;
            if (~&stall_cnt) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end else begin
            ex_valid <= id_valid;
            ex_pc    <= id_pc;
            ex_rs1   <= id_rs1;
            ex_rs2   <= id_rs2;
            ex_rd    <= id_rd;
            ex_a     <= opa;
            ex_b     <= opb;
            ex_imm   <= id_imm;
            ex_ctrl  <= id_ctrl;
            ex_ruwr  <= id_ruwr & id_valid;
            ex_dmrd  <= id_dmrd & id_valid;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with a queue-based scoreboard.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_id_ex_stage;

    typedef struct {
        logic        v;
        logic        w;
        logic        d;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [15:0] s;
        logic [15:0] f;
        bit          sat;
        logic [1:0]  satc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [31:0] id_imm;
    logic [7:0]  id_ctrl;
    logic        id_ruwr;
    logic        id_dmrd;
    logic [31:0] ru1;
    logic [31:0] ru2;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ruwr;
    logic        ex_flush;

    logic        stall_if_id;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [31:0] ex_imm;
    logic [7:0]  ex_ctrl;
    logic        ex_ruwr;
    logic        ex_dmrd;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    logic        u1_stall;
    logic        u1_valid;
    logic [31:0] u1_pc;
    logic [4:0]  u1_rs1;
    logic [4:0]  u1_rs2;
    logic [4:0]  u1_rd;
    logic [31:0] u1_a;
    logic [31:0] u1_b;
    logic [31:0] u1_imm;
    logic [7:0]  u1_ctrl;
    logic        u1_ruwr;
    logic        u1_dmrd;
    logic [1:0]  u1_scnt;
    logic [1:0]  u1_fcnt;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    id_ex_stage u0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_imm(id_imm), .id_ctrl(id_ctrl), .id_ruwr(id_ruwr),
        .id_dmrd(id_dmrd), .ru1(ru1), .ru2(ru2), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_ruwr(wb_ruwr), .ex_flush(ex_flush),
        .stall_if_id(stall_if_id), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_a(ex_a),
        .ex_b(ex_b), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .ex_ruwr(ex_ruwr), .ex_dmrd(ex_dmrd), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    id_ex_stage #(.CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_imm(id_imm), .id_ctrl(id_ctrl), .id_ruwr(id_ruwr),
        .id_dmrd(id_dmrd), .ru1(ru1), .ru2(ru2), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_ruwr(wb_ruwr), .ex_flush(ex_flush),
        .stall_if_id(u1_stall), .ex_valid(u1_valid), .ex_pc(u1_pc),
        .ex_rs1(u1_rs1), .ex_rs2(u1_rs2), .ex_rd(u1_rd), .ex_a(u1_a),
        .ex_b(u1_b), .ex_imm(u1_imm), .ex_ctrl(u1_ctrl),
        .ex_ruwr(u1_ruwr), .ex_dmrd(u1_dmrd), .stall_cnt(u1_scnt),
        .flush_cnt(u1_fcnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(logic v, logic w, logic d,
                                logic [31:0] pc, logic [31:0] a,
                                logic [31:0] b, logic [4:0] rd,
                                logic [15:0] s, logic [15:0] f);
        exp_t e;
        e.v = v; e.w = w; e.d = d; e.pc = pc; e.a = a; e.b = b;
        e.rd = rd; e.s = s; e.f = f; e.sat = 1'b0; e.satc = 2'd0;
        return e;
    endfunction

    task automatic drv(input logic v, input logic [31:0] pc,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic w,
                       input logic d, input logic [31:0] a,
                       input logic [31:0] b);
        id_valid = v; id_pc = pc; id_rs1 = r1; id_rs2 = r2;
        id_rd = rd; id_ruwr = w; id_dmrd = d; ru1 = a; ru2 = b;
        id_imm = ~pc; id_ctrl = pc[9:2];
    endtask

    // Inputs are driven just after a falling edge before calling this.
    task automatic step(input exp_t e, input logic es);
        exp_t g;
        #1;
        chk("stall_if_id", 32'(stall_if_id), 32'(es));
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            g = sb.pop_front();
            chk("ex_valid", 32'(ex_valid), 32'(g.v));
            chk("ex_ruwr", 32'(ex_ruwr), 32'(g.w));
            chk("ex_dmrd", 32'(ex_dmrd), 32'(g.d));
            chk("stall_cnt", 32'(stall_cnt), 32'(g.s));
            chk("flush_cnt", 32'(flush_cnt), 32'(g.f));
            if (g.v) begin
                chk("ex_pc", ex_pc, g.pc);
                chk("ex_a", ex_a, g.a);
                chk("ex_b", ex_b, g.b);
                chk("ex_rd", 32'(ex_rd), 32'(g.rd));
                chk("ex_imm", ex_imm, ~g.pc);
                chk("ex_ctrl", 32'(ex_ctrl), 32'(g.pc[9:2]));
            end
            if (g.sat) begin
                chk("sat_stall", 32'(u1_scnt), 32'(g.satc));
                chk("sat_flush", 32'(u1_fcnt), 32'd0);
            end
        end
        @(negedge clk);
    endtask

    logic [31:0] bypa;
    exp_t        e;

    initial begin
`ifdef ID_EX_WB_BYPASS_EN
        bypa = 32'h12345678;
`else
        bypa = 32'h0000DEAD;
`endif
        rst = 1'b1;
        ex_flush = 1'b0;
        wb_rd = 5'd0; wb_data = 32'd0; wb_ruwr = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
        rst = 1'b0;

        // capture
        drv(1, 32'h100, 1, 2, 3, 1, 0, 32'hAAAA0000, 32'h5555);
        step(mk(1, 1, 0, 32'h100, 32'hAAAA0000, 32'h5555, 3, 0, 0), 0);
        // load rd=5
        drv(1, 32'h104, 1, 2, 5, 1, 1, 32'h11, 32'h22);
        step(mk(1, 1, 1, 32'h104, 32'h11, 32'h22, 5, 0, 0), 0);
        // use via rs2: bubble
        drv(1, 32'h108, 6, 5, 8, 1, 0, 32'h33, 32'h44);
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), 1);
        // held instruction proceeds
        step(mk(1, 1, 0, 32'h108, 32'h33, 32'h44, 8, 1, 0), 0);
        // load to x0
        drv(1, 32'h10C, 8, 9, 0, 1, 1, 32'h1, 32'h2);
        step(mk(1, 1, 1, 32'h10C, 32'h1, 32'h2, 0, 1, 0), 0);
        // rs1=0 against x0 load: no stall
        drv(1, 32'h110, 0, 3, 4, 1, 0, 32'h3, 32'h4);
        step(mk(1, 1, 0, 32'h110, 32'h3, 32'h4, 4, 1, 0), 0);
        // load rd=9
        drv(1, 32'h114, 1, 2, 9, 1, 1, 32'h5, 32'h6);
        step(mk(1, 1, 1, 32'h114, 32'h5, 32'h6, 9, 1, 0), 0);
        // hazard plus flush: flush wins
        drv(1, 32'h118, 9, 2, 10, 1, 0, 32'h55, 32'h66);
        ex_flush = 1'b1;
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1), 0);
        ex_flush = 1'b0;
        step(mk(1, 1, 0, 32'h118, 32'h55, 32'h66, 10, 1, 1), 0);
        // same-cycle WB on rs1
        drv(1, 32'h11C, 7, 2, 11, 1, 0, 32'hDEAD, 32'hBEEF);
        wb_ruwr = 1'b1; wb_rd = 5'd7; wb_data = 32'h12345678;
        step(mk(1, 1, 0, 32'h11C, bypa, 32'hBEEF, 11, 1, 1), 0);
        // WB to x0 never bypasses
        drv(1, 32'h120, 0, 0, 12, 0, 0, 32'h77, 32'h88);
        wb_rd = 5'd0;
        step(mk(1, 0, 0, 32'h120, 32'h77, 32'h88, 12, 1, 1), 0);
        wb_ruwr = 1'b0;
        // invalid load: flags gated
        drv(0, 32'h124, 1, 2, 5, 1, 1, 32'h9, 32'hA);
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1), 0);
        // rs2=5 after invalid load: no stall
        drv(1, 32'h128, 1, 5, 5, 1, 1, 32'hB, 32'hC);
        step(mk(1, 1, 1, 32'h128, 32'hB, 32'hC, 5, 1, 1), 0);
        // reset with hazard present: stall masked, all cleared
        drv(1, 32'h12C, 5, 5, 6, 1, 0, 32'hD, 32'hE);
        rst = 1'b1;
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
        rst = 1'b0;

        // five load-use hazards; 2-bit counter pins at 3
        for (int i = 0; i < 5; i++) begin
            drv(1, 32'h200 + 32'(i * 8), 1, 2, 5, 1, 1, 32'h1, 32'h2);
            step(mk(1, 1, 1, 32'h200 + 32'(i * 8), 32'h1, 32'h2, 5,
                    16'(i), 0), 0);
            drv(1, 32'h204 + 32'(i * 8), 3, 5, 6, 1, 0, 32'h3, 32'h4);
            e = mk(0, 0, 0, 0, 0, 0, 0, 16'(i + 1), 0);
            e.sat = 1'b1;
            e.satc = (i >= 2) ? 2'd3 : 2'(i + 1);
            step(e, 1);
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        e = mk(0, 0, 0, 0, 0, 0, 0, 5, 0);
        e.sat = 1'b1;
        e.satc = 2'd3;
        step(e, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
